// File: rtl/access_blk_lookup_pipe.sv
// Two-stage tag-match pipeline: S1 captures the request and the set read, S2 holds the registered match result.
// Valid/ready back-pressure on both ends; non-snoop, well-formed lookups feed saturating hit/miss counters.
module access_blk_lookup_pipe #(
    parameter int ASSOC     = 4,
    parameter int ASSOC_WID = 2,
    parameter int MESI_WID  = 2,
    parameter int TAG_WID   = 16,
    parameter int INVALID   = 0,
    parameter int SHARED    = 1,
    parameter int CNT_WID   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        cmd_rd,
    input  logic                        cmd_wr,
    input  logic                        cmd_snoop,
    input  logic [TAG_WID-1:0]          tag_req,
    input  logic [ASSOC*MESI_WID-1:0]   cache_mesi,
    input  logic [ASSOC*TAG_WID-1:0]    cache_tag,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ASSOC-1:0]            access_blk,
    output logic                        hit,
    output logic [ASSOC_WID-1:0]        hit_way,
    output logic                        upgrade,
    output logic                        out_snoop,
    output logic                        multi_hit,
    output logic                        cmd_err,
    output logic [CNT_WID-1:0]          hit_cnt,
    output logic [CNT_WID-1:0]          miss_cnt
);

    localparam int NM_WID = $clog2(ASSOC + 1);
    localparam logic [MESI_WID-1:0] MESI_INV = MESI_WID'(INVALID);
    localparam logic [MESI_WID-1:0] MESI_SHR = MESI_WID'(SHARED);

    logic                      s1_valid_q;
    logic                      s1_rd_q, s1_wr_q, s1_snp_q;
    logic [TAG_WID-1:0]        s1_tag_q;
    logic [ASSOC*MESI_WID-1:0] s1_mesi_q;
    logic [ASSOC*TAG_WID-1:0]  s1_ctag_q;

    logic                      out_valid_q;
    logic [ASSOC-1:0]          access_blk_q, access_blk_d;
    logic                      hit_q, hit_d;
    logic [ASSOC_WID-1:0]      hit_way_q, hit_way_d;
    logic                      upgrade_q, upgrade_d;
    logic                      out_snoop_q;
    logic                      multi_hit_q, multi_hit_d;
    logic                      cmd_err_q, cmd_err_d;
    logic [CNT_WID-1:0]        hit_cnt_q, miss_cnt_q;

    logic [1:0]                cmd_cnt_d;
    logic [NM_WID-1:0]         nmatch_d;
    logic [MESI_WID-1:0]       way_mesi_d;

    logic s2_adv, s1_adv, accept, out_hs;

    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = rst_n && s1_adv;
    assign accept   = in_valid && in_ready;
    assign out_hs   = out_valid_q && out_ready;

    always_comb begin
        cmd_cnt_d    = 2'(s1_rd_q) + 2'(s1_wr_q) + 2'(s1_snp_q);
        cmd_err_d    = (cmd_cnt_d != 2'd1);
        access_blk_d = '0;
        hit_way_d    = '0;
        way_mesi_d   = '0;
        hit_d        = 1'b0;
        nmatch_d     = '0;
        for (int i = 0; i < ASSOC; i++) begin
            if (!cmd_err_d
                && (s1_mesi_q[i*MESI_WID +: MESI_WID] != MESI_INV)
                && (s1_ctag_q[i*TAG_WID +: TAG_WID] == s1_tag_q)) begin
                access_blk_d[i] = 1'b1;
                nmatch_d        = nmatch_d + NM_WID'(1);
                // first match wins: lowest way index is the reported hit way
                if (!hit_d) begin
                    hit_d      = 1'b1;
                    hit_way_d  = ASSOC_WID'(i);
                    way_mesi_d = s1_mesi_q[i*MESI_WID +: MESI_WID];
                end
            end
        end
        multi_hit_d = (nmatch_d > NM_WID'(1));
        upgrade_d   = s1_wr_q && hit_d && (way_mesi_d == MESI_SHR);
    end

    // request payload needs no reset; it is only consumed behind s1_valid_q
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_rd_q   <= cmd_rd;
            s1_wr_q   <= cmd_wr;
            s1_snp_q  <= cmd_snoop;
            s1_tag_q  <= tag_req;
            s1_mesi_q <= cache_mesi;
            s1_ctag_q <= cache_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            access_blk_q <= '0;
            hit_q        <= 1'b0;
            hit_way_q    <= '0;
            upgrade_q    <= 1'b0;
            out_snoop_q  <= 1'b0;
            multi_hit_q  <= 1'b0;
            cmd_err_q    <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= accept;
            end
            if (s2_adv) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    access_blk_q <= access_blk_d;
                    hit_q        <= hit_d;
                    hit_way_q    <= hit_way_d;
                    upgrade_q    <= upgrade_d;
                    out_snoop_q  <= s1_snp_q;
                    multi_hit_q  <= multi_hit_d;
                    cmd_err_q    <= cmd_err_d;
                end
            end
            if (out_hs && !cmd_err_q && !out_snoop_q) begin
                if (hit_q) begin
                    if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + CNT_WID'(1);
                end else begin
                    if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + CNT_WID'(1);
                end
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign access_blk = access_blk_q;
    assign hit        = hit_q;
    assign hit_way    = hit_way_q;
    assign upgrade    = upgrade_q;
    assign out_snoop  = out_snoop_q;
    assign multi_hit  = multi_hit_q;
    assign cmd_err    = cmd_err_q;
    assign hit_cnt    = hit_cnt_q;
    assign miss_cnt   = miss_cnt_q;

endmodule
